// File: rtl/ddr2pbuf_gen_pkg.sv
// Shared types and global constants for the DDR-to-pbuf loader.
package ddr2pbuf_gen_pkg;
  localparam int BATCH    = 4;
  localparam int DATA_W   = 8;
  localparam int PBUF_GRP = 4;

  typedef enum logic [1:0] {PB_BCAST, PB_SCATTER, PB_UPDATE, PB_RSVD} pbuf_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} pbuf_state_e;
endpackage

// File: rtl/ddr2pbuf_gen_update_addr_gen.sv
// UPDATE-mode ch/pix/row counter nest (ch innermost) with pbuf address,
// target lane and the flag marking the final beat of the job.
module update_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int GRP    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     advance,
  input  logic [3:0]               ch_num,
  input  logic [3:0]               pix_num,
  input  logic [1:0]               row_num,
  input  logic                     depool,
  output logic [ADDR_W-1:0]        addr,
  output logic [$clog2(GRP)-1:0]   lane,
  output logic                     last
);
  localparam int LW = $clog2(GRP);

  logic [3:0] ch;
  logic [3:0] pix;
  logic [1:0] row;
  logic [4:0] pix_next;
  logic [2:0] row_next;
  logic       ch_wrap;
  logic       pix_wrap;
  logic       row_wrap;
  logic [7:0] raw_addr;

  // Widened sums so an overshoot past the last index is visible as a wrap.
  assign pix_next = {1'b0, pix} + (depool ? 5'd2 : 5'd1);
  assign row_next = {1'b0, row} + (depool ? 3'd2 : 3'd1);
  assign ch_wrap  = (ch == ch_num);
  assign pix_wrap = (pix_next > {1'b0, pix_num});
  assign row_wrap = (row_next > {1'b0, row_num});
  assign last     = ch_wrap && pix_wrap && row_wrap;

  assign raw_addr = {ch, row[1], pix[3:1]};
  assign addr     = ADDR_W'(raw_addr);
  assign lane     = LW'({row[0], pix[0]});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ch  <= '0;
      pix <= '0;
      row <= '0;
    end else if (advance) begin
      if (!ch_wrap) begin
        ch <= ch + 4'd1;
      end else begin
        ch <= '0;
        if (pix_wrap) begin
          pix <= '0;
          row <= row_wrap ? 2'd0 : row_next[1:0];
        end else begin
          pix <= pix_next[3:0];
        end
      end
    end
  end
endmodule

// File: rtl/ddr2pbuf_gen.sv
// Parameter-buffer loader: moves DDR beats into the per-PE pbufs in
// BCAST, SCATTER or UPDATE mode with valid/ready flow control.
module ddr2pbuf_gen
  import ddr2pbuf_gen_pkg::*;
#(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int PE_NUM    = 32,
  parameter int GRP       = ddr2pbuf_gen_pkg::PBUF_GRP,
  parameter int BATCH     = ddr2pbuf_gen_pkg::BATCH,
  parameter int DATA_W    = ddr2pbuf_gen_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          conf_valid,
  output logic                          conf_ready,
  input  logic [1:0]                    conf_mode,
  input  logic [11:0]                   conf_trans_num,
  input  logic [3:0]                    conf_ch_num,
  input  logic [3:0]                    conf_pix_num,
  input  logic [1:0]                    conf_row_num,
  input  logic                          conf_depool,
  input  logic [PE_NUM-1:0]             conf_mask,
  input  logic [BATCH*DATA_W-1:0]       ddr1_data,
  input  logic                          ddr1_valid,
  output logic                          ddr1_ready,
  input  logic [BATCH*DATA_W-1:0]       ddr2_data,
  input  logic                          ddr2_valid,
  output logic                          ddr2_ready,
  output logic [GRP*BATCH*DATA_W-1:0]   pbuf_wr_data,
  output logic [ADDR_W-1:0]             pbuf_wr_addr,
  output logic [PE_NUM-1:0]             pbuf_wr_en,
  output logic                          done
);
  localparam int DDR_W = BATCH * DATA_W;
  localparam int LW    = $clog2(GRP);

  pbuf_state_e state, state_nxt;
  pbuf_mode_e  mode_q;
  logic [11:0]       trans_q;
  logic [11:0]       beat_q;
  logic [3:0]        ch_q;
  logic [3:0]        pix_q;
  logic [1:0]        row_q;
  logic              depool_q;
  logic [PE_NUM-1:0] mask_q;

  logic              conf_accept;
  logic              run;
  logic              is_upd;
  logic              accept;
  logic              last_beat;
  logic [ADDR_W-1:0] upd_addr;
  logic [LW-1:0]     upd_lane;
  logic              upd_last;

  logic [GRP*DDR_W-1:0] data_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [PE_NUM-1:0]    en_nxt;

  function automatic logic [PE_NUM-1:0] lane_mask(input logic [LW-1:0] lane);
    logic [PE_NUM-1:0] m;
    m = '0;
    for (int p = 0; p < PE_NUM; p++) m[p] = ((p % GRP) == int'(lane));
    return m;
  endfunction

  assign conf_accept = (state == ST_IDLE) && conf_valid;
  assign run         = (state == ST_RUN);
  assign is_upd      = (mode_q == PB_UPDATE);

  // Each stream's ready looks only at its partner's valid, so UPDATE never
  // consumes one stream without the other.
  assign ddr1_ready = run && is_upd && ddr2_valid;
  assign ddr2_ready = run && (is_upd ? ddr1_valid : 1'b1);
  assign accept     = run && (is_upd ? (ddr1_valid && ddr2_valid) : ddr2_valid);
  assign last_beat  = is_upd ? upd_last : (beat_q == trans_q - 12'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    conf_ready = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        conf_ready = 1'b1;
        if (conf_valid) begin
          if (conf_mode == PB_RSVD ||
              (conf_mode != PB_UPDATE && conf_trans_num == 12'd0))
            state_nxt = ST_FLUSH;
          else
            state_nxt = ST_RUN;
        end
      end
      ST_RUN:   if (accept && last_beat) state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= PB_BCAST;
      trans_q  <= '0;
      ch_q     <= '0;
      pix_q    <= '0;
      row_q    <= '0;
      depool_q <= 1'b0;
      mask_q   <= '0;
    end else if (conf_accept) begin
      mode_q   <= pbuf_mode_e'(conf_mode);
      trans_q  <= conf_trans_num;
      ch_q     <= conf_ch_num;
      pix_q    <= conf_pix_num;
      row_q    <= conf_row_num;
      depool_q <= conf_depool;
      mask_q   <= conf_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || conf_accept)    beat_q <= '0;
    else if (accept && !is_upd) beat_q <= beat_q + 12'd1;
  end

  update_addr_gen #(.ADDR_W(ADDR_W), .GRP(GRP)) u_upd (
    .clk     (clk),
    .rst     (rst),
    .clear   (conf_accept),
    .advance (accept && is_upd),
    .ch_num  (ch_q),
    .pix_num (pix_q),
    .row_num (row_q),
    .depool  (depool_q),
    .addr    (upd_addr),
    .lane    (upd_lane),
    .last    (upd_last)
  );

  always_comb begin
    data_nxt = {GRP{ddr2_data}};
    addr_nxt = ADDR_W'(32'(beat_q) % 32'(BUF_DEPTH));
    en_nxt   = mask_q;
    case (mode_q)
      PB_SCATTER: begin
        addr_nxt = ADDR_W'((32'(beat_q) >> LW) % 32'(BUF_DEPTH));
        en_nxt   = mask_q & lane_mask(beat_q[LW-1:0]);
      end
      PB_UPDATE: begin
        addr_nxt = upd_addr;
        if (depool_q) begin
          // Depool: ddr2 carries a per-lane, per-element switch mask.
          for (int j = 0; j < GRP; j++)
            for (int i = 0; i < BATCH; i++)
              if (j * BATCH + i < DDR_W && ddr2_data[j*BATCH+i])
                data_nxt[j*DDR_W+i*DATA_W +: DATA_W] = ddr1_data[i*DATA_W +: DATA_W];
              else
                data_nxt[j*DDR_W+i*DATA_W +: DATA_W] = '0;
        end else begin
          data_nxt = {GRP{ddr1_data}};
          en_nxt   = mask_q & lane_mask(upd_lane);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pbuf_wr_en   <= '0;
      pbuf_wr_addr <= '0;
      pbuf_wr_data <= '0;
    end else if (accept) begin
      pbuf_wr_en   <= en_nxt;
      pbuf_wr_addr <= addr_nxt;
      pbuf_wr_data <= data_nxt;
    end else begin
      pbuf_wr_en   <= '0;
    end
  end
endmodule

// File: tb/tb_ddr2pbuf_gen.sv
// Directed scoreboard bench for ddr2pbuf_gen: expected writes are queued
// when a beat is handed over and checked when the pbuf write appears.
module tb_ddr2pbuf_gen;
  logic         clk;
  logic         rst;
  logic         conf_valid;
  logic         conf_ready;
  logic [1:0]   conf_mode;
  logic [11:0]  conf_trans_num;
  logic [3:0]   conf_ch_num;
  logic [3:0]   conf_pix_num;
  logic [1:0]   conf_row_num;
  logic         conf_depool;
  logic [31:0]  conf_mask;
  logic [31:0]  ddr1_data;
  logic         ddr1_valid;
  logic         ddr1_ready;
  logic [31:0]  ddr2_data;
  logic         ddr2_valid;
  logic         ddr2_ready;
  logic [127:0] pbuf_wr_data;
  logic [7:0]   pbuf_wr_addr;
  logic [31:0]  pbuf_wr_en;
  logic         done;

  typedef struct {
    logic [7:0]   addr;
    logic [31:0]  en;
    logic [127:0] data;
    logic [127:0] dmask;
    logic         last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  ddr2pbuf_gen #(.BUF_DEPTH(256), .ADDR_W(8), .PE_NUM(32), .GRP(4), .BATCH(4), .DATA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .conf_valid     (conf_valid),
    .conf_ready     (conf_ready),
    .conf_mode      (conf_mode),
    .conf_trans_num (conf_trans_num),
    .conf_ch_num    (conf_ch_num),
    .conf_pix_num   (conf_pix_num),
    .conf_row_num   (conf_row_num),
    .conf_depool    (conf_depool),
    .conf_mask      (conf_mask),
    .ddr1_data      (ddr1_data),
    .ddr1_valid     (ddr1_valid),
    .ddr1_ready     (ddr1_ready),
    .ddr2_data      (ddr2_data),
    .ddr2_valid     (ddr2_valid),
    .ddr2_ready     (ddr2_ready),
    .pbuf_wr_data   (pbuf_wr_data),
    .pbuf_wr_addr   (pbuf_wr_addr),
    .pbuf_wr_en     (pbuf_wr_en),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane_mask(input int lane);
    logic [31:0] m;
    for (int p = 0; p < 32; p++) m[p] = ((p % 4) == lane);
    return m;
  endfunction

  // Write stream monitor: every write must match the oldest queued beat.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (pbuf_wr_en !== 32'h0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 128'(pbuf_wr_en), 128'h0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("wr_addr", 128'(pbuf_wr_addr), 128'(mon_e.addr));
        checkOutput("wr_en", 128'(pbuf_wr_en), 128'(mon_e.en));
        checkOutput("wr_data", pbuf_wr_data & mon_e.dmask, mon_e.data & mon_e.dmask);
        checkOutput("done_with_last", 128'(done), 128'(mon_e.last));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] mode, input logic [11:0] tn, input logic [3:0] ch,
                               input logic [3:0] pix, input logic [1:0] row, input logic dp,
                               input logic [31:0] mask);
    int w = 0;
    while (conf_ready !== 1'b1 && w < 20) begin step(); w++; end
    checkOutput("conf_ready_idle", 128'(conf_ready), 128'h1);
    conf_mode = mode; conf_trans_num = tn; conf_ch_num = ch; conf_pix_num = pix;
    conf_row_num = row; conf_depool = dp; conf_mask = mask; conf_valid = 1'b1;
    step();
    conf_valid = 1'b0;
    conf_mode = 2'($urandom); conf_trans_num = 12'($urandom); conf_mask = $urandom;
    conf_ch_num = 4'($urandom); conf_pix_num = 4'($urandom); conf_depool = 1'($urandom);
  endtask

  // BCAST/SCATTER beats on ddr2; valid is high one cycle in every gap+1.
  task automatic feed_beats(input int mode, input int n, input logic [31:0] mask,
                            input int gap, input int abort_at);
    int   k = 0;
    int   cyc = 0;
    exp_t e;
    while (k < n && k != abort_at && cyc < 300) begin
      ddr2_valid = ((cyc % (gap + 1)) == 0);
      ddr2_data  = $urandom;
      ddr1_valid = 1'($urandom);
      #1;
      checkOutput("ddr2_ready_run", 128'(ddr2_ready), 128'h1);
      checkOutput("ddr1_ready_run", 128'(ddr1_ready), 128'h0);
      if (ddr2_valid) begin
        e.addr  = 8'(mode == 1 ? (k / 4) % 256 : k % 256);
        e.en    = (mode == 1) ? (mask & lane_mask(k % 4)) : mask;
        e.data  = {4{ddr2_data}};
        e.dmask = (mode == 1) ? (128'(32'hFFFF_FFFF) << (32 * (k % 4))) : {128{1'b1}};
        e.last  = (k == n - 1);
        sb.push_back(e);
        k++;
      end
      step();
      cyc++;
    end
    if (k < n && k != abort_at) checkOutput("feed_timeout", 128'(k), 128'(n));
  endtask

  task automatic feed_update(input int ch_n, input int pix_n, input int row_n, input logic dp,
                             input logic [31:0] mask, input logic [31:0] sw,
                             input int stall_start, input int stall_len);
    int   chs[$], pixs[$], rows[$];
    int   st = dp ? 2 : 1;
    int   k = 0;
    int   cyc = 0;
    int   n;
    exp_t e;
    for (int r = 0; r <= row_n; r += st)
      for (int p = 0; p <= pix_n; p += st)
        for (int c = 0; c <= ch_n; c++) begin
          chs.push_back(c); pixs.push_back(p); rows.push_back(r);
        end
    n = chs.size();
    while (k < n && cyc < 300) begin
      ddr1_valid = !(cyc >= stall_start && cyc < stall_start + stall_len);
      ddr2_valid = (cyc != stall_start + stall_len + 1);
      ddr1_data  = $urandom | 32'h1;
      ddr2_data  = dp ? sw : $urandom;
      #1;
      checkOutput("ddr1_ready_upd", 128'(ddr1_ready), 128'(ddr2_valid));
      checkOutput("ddr2_ready_upd", 128'(ddr2_ready), 128'(ddr1_valid));
      if (ddr1_valid && ddr2_valid) begin
        e.addr  = 8'((chs[k] << 4) | (((rows[k] >> 1) & 1) << 3) | ((pixs[k] >> 1) & 7));
        e.dmask = {128{1'b1}};
        e.last  = (k == n - 1);
        if (dp) begin
          e.en   = mask;
          e.data = '0;
          for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
              if (sw[j*4+i]) e.data[j*32+i*8 +: 8] = ddr1_data[i*8 +: 8];
        end else begin
          e.en   = mask & lane_mask((((rows[k] & 1) << 1) | (pixs[k] & 1)) % 4);
          e.data = {4{ddr1_data}};
        end
        sb.push_back(e);
        k++;
      end
      step();
      cyc++;
    end
    if (k < n) checkOutput("update_timeout", 128'(k), 128'(n));
  endtask

  // Right after the final accept: both streams offered, neither may be taken.
  task automatic check_job_end(input int exp_done);
    int w = 0;
    ddr1_valid = 1'b1; ddr2_valid = 1'b1;
    ddr1_data = $urandom; ddr2_data = $urandom;
    #1;
    checkOutput("ddr2_ready_flush", 128'(ddr2_ready), 128'h0);
    checkOutput("ddr1_ready_flush", 128'(ddr1_ready), 128'h0);
    step();
    checkOutput("ddr2_ready_after", 128'(ddr2_ready), 128'h0);
    checkOutput("conf_ready_after", 128'(conf_ready), 128'h1);
    ddr1_valid = 1'b0; ddr2_valid = 1'b0;
    while (sb.size() != 0 && w < 20) begin step(); w++; end
    checkOutput("sb_drained", 128'(sb.size()), 128'h0);
    step(); step();
    checkOutput("done_count", 128'(done_cnt), 128'(exp_done));
  endtask

  initial begin
    rst = 1'b1; conf_valid = 1'b0; conf_mode = '0; conf_trans_num = '0; conf_ch_num = '0;
    conf_pix_num = '0; conf_row_num = '0; conf_depool = 1'b0; conf_mask = '0;
    ddr1_data = '0; ddr2_data = '0; ddr1_valid = 1'b1; ddr2_valid = 1'b1;
    repeat (3) step();
    $display("[TB] reset state");
    checkOutput("rst_conf_ready", 128'(conf_ready), 128'h1);
    checkOutput("rst_ddr1_ready", 128'(ddr1_ready), 128'h0);
    checkOutput("rst_ddr2_ready", 128'(ddr2_ready), 128'h0);
    checkOutput("rst_wr_en", 128'(pbuf_wr_en), 128'h0);
    checkOutput("rst_wr_addr", 128'(pbuf_wr_addr), 128'h0);
    checkOutput("rst_wr_data", pbuf_wr_data, 128'h0);
    checkOutput("rst_done", 128'(done), 128'h0);
    rst = 1'b0; ddr1_valid = 1'b0; ddr2_valid = 1'b0;
    step();

    $display("[TB] BCAST 5 beats");
    applyStimulus(2'd0, 12'd5, 4'd0, 4'd0, 2'd0, 1'b0, 32'h0000_00F0);
    feed_beats(0, 5, 32'h0000_00F0, 0, -1);
    check_job_end(1);

    $display("[TB] SCATTER 10 beats");
    applyStimulus(2'd1, 12'd10, 4'd0, 4'd0, 2'd0, 1'b0, 32'hFFFF_FFFF);
    feed_beats(1, 10, 32'hFFFF_FFFF, 0, -1);
    check_job_end(2);

    $display("[TB] BCAST 6 beats, gappy valid");
    applyStimulus(2'd0, 12'd6, 4'd0, 4'd0, 2'd0, 1'b0, 32'h8000_0001);
    feed_beats(0, 6, 32'h8000_0001, 2, -1);
    check_job_end(3);

    $display("[TB] UPDATE no depool with ddr1 stall");
    applyStimulus(2'd2, 12'd0, 4'd1, 4'd1, 2'd1, 1'b0, 32'hFFFF_FFFF);
    feed_update(1, 1, 1, 1'b0, 32'hFFFF_FFFF, 32'h0, 2, 3);
    check_job_end(4);

    $display("[TB] UPDATE depool");
    applyStimulus(2'd2, 12'd0, 4'd0, 4'd3, 2'd1, 1'b1, 32'h0F0F_0F0F);
    feed_update(0, 3, 1, 1'b1, 32'h0F0F_0F0F, 32'h0000_0001, 1, 1);
    check_job_end(5);

    $display("[TB] reset mid-BCAST");
    applyStimulus(2'd0, 12'd8, 4'd0, 4'd0, 2'd0, 1'b0, 32'hFFFF_FFFF);
    feed_beats(0, 8, 32'hFFFF_FFFF, 0, 3);
    rst = 1'b1;
    step();
    checkOutput("abort_conf_ready", 128'(conf_ready), 128'h1);
    checkOutput("abort_ddr2_ready", 128'(ddr2_ready), 128'h0);
    checkOutput("abort_wr_en", 128'(pbuf_wr_en), 128'h0);
    rst = 1'b0; ddr2_valid = 1'b0;
    repeat (5) step();
    checkOutput("abort_sb_empty", 128'(sb.size()), 128'h0);
    checkOutput("abort_no_done", 128'(done_cnt), 128'd5);
    applyStimulus(2'd1, 12'd4, 4'd0, 4'd0, 2'd0, 1'b0, 32'hFFFF_0000);
    feed_beats(1, 4, 32'hFFFF_0000, 1, -1);
    check_job_end(6);

    $display("[TB] zero-length and reserved jobs");
    applyStimulus(2'd0, 12'd0, 4'd0, 4'd0, 2'd0, 1'b0, 32'hFFFF_FFFF);
    ddr2_valid = 1'b1; ddr1_valid = 1'b1;
    #1;
    checkOutput("zero_ddr2_ready", 128'(ddr2_ready), 128'h0);
    checkOutput("zero_done", 128'(done), 128'h1);
    ddr2_valid = 1'b0; ddr1_valid = 1'b0;
    step();
    applyStimulus(2'd3, 12'd7, 4'd0, 4'd0, 2'd0, 1'b0, 32'hFFFF_FFFF);
    ddr2_valid = 1'b1; ddr1_valid = 1'b1;
    #1;
    checkOutput("rsvd_ddr1_ready", 128'(ddr1_ready), 128'h0);
    checkOutput("rsvd_ddr2_ready", 128'(ddr2_ready), 128'h0);
    checkOutput("rsvd_done", 128'(done), 128'h1);
    ddr2_valid = 1'b0; ddr1_valid = 1'b0;
    repeat (3) step();
    checkOutput("final_sb_empty", 128'(sb.size()), 128'h0);
    checkOutput("final_done_count", 128'(done_cnt), 128'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr2pbuf_gen.md
Name: ddr2pbuf_gen

Overview:
Parametrised parameter-buffer loader. It takes beats from two DDR read streams and writes them into the per-PE parameter buffers (pbuf). Compared with the fixed 32-PE / 4-lane loader it adds:
- real valid/ready backpressure;
- exact beat-count termination;
- a configurable lane count;
- a new SCATTER mode;
- an explicit done pulse.

It sits between the DDR read DMA and the PE array, and is driven by the layer controller through a conf handshake.

Parameters:
BUF_DEPTH, 256, pbuf words per PE
ADDR_W, bw(BUF_DEPTH), pbuf address width
PE_NUM, 32, number of PEs; must be a multiple of GRP
GRP, 4, write lanes per PE group; power of two, 2..8
BATCH, GLOBAL_PARAM::BATCH, elements per DDR beat
DATA_W, GLOBAL_PARAM::DATA_W, element width; DDR_W = BATCH*DATA_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
conf_valid  in  1  configuration valid
conf_ready  out  1  high only in IDLE
conf_mode  in  2  0=BCAST, 1=SCATTER, 2=UPDATE, 3=reserved
conf_trans_num  in  12  beats to transfer (BCAST/SCATTER)
conf_ch_num  in  4  last channel index (UPDATE)
conf_pix_num  in  4  last pixel index (UPDATE)
conf_row_num  in  2  last row index (UPDATE)
conf_depool  in  1  depool enable (UPDATE)
conf_mask  in  PE_NUM  PE write mask
ddr1_data  in  DDR_W  gradient stream
ddr1_valid  in  1  gradient stream valid
ddr1_ready  out  1  gradient stream ready
ddr2_data  in  DDR_W  parameter stream / depool switch mask
ddr2_valid  in  1  parameter stream valid
ddr2_ready  out  1  parameter stream ready
pbuf_wr_data  out  GRP x DDR_W  per-lane write data
pbuf_wr_addr  out  ADDR_W  write address, common to all PEs
pbuf_wr_en  out  PE_NUM  per-PE write enable; PE p is lane p%GRP
done  out  1  one-cycle pulse at end of job

Behaviour:
FSM states are IDLE, RUN and FLUSH.

IDLE:
- conf_ready=1.
- conf_valid && conf_ready: latch all conf_* fields and clear all counters.
- Next state is RUN for modes 0–2; for mode 3 it is FLUSH, with no writes and no ready.
- Latched conf fields stay stable until the next accept. conf_valid is ignored outside IDLE.

RUN, per-mode handshake and write behaviour:
- BCAST:
  - ddr2_ready=1, ddr1_ready=0.
  - Each accepted beat k writes to all lanes with the same data, at addr = k mod BUF_DEPTH.
  - Enables: every PE in conf_mask.
- SCATTER:
  - Handshake as BCAST.
  - Beat k: lane = k%GRP, addr = (k/GRP) mod BUF_DEPTH.
  - Enables: masked PEs whose p%GRP == lane.
- UPDATE, accept rule:
  - ddr1_ready = ddr2_valid and ddr2_ready = ddr1_valid; a beat is accepted only when both are valid.
  - Neither stream is consumed alone.
- UPDATE, counter nest (ch innermost):
  - ch runs 0..conf_ch_num.
  - On ch wrap, pix += step, with step = depool ? 2 : 1.
  - pix wraps to 0 when pix+step > conf_pix_num, and then row += step.
- UPDATE, addressing and data:
  - Address is {ch, row[1], pix[3:1]}, zero-extended to ADDR_W.
  - Non-depool: all lanes carry ddr1 data. Enables go to masked PEs whose lane == {row[0], pix[0]} mod GRP.
  - Depool: lane j, element i = ddr2_data bit (j*BATCH+i) ? ddr1 element i : 0. Enables go to all masked PEs.

RUN termination:
- BCAST/SCATTER: the accept of beat conf_trans_num-1 ends the job.
- UPDATE: the accept where ch, pix and row all wrap ends the job.
- conf_trans_num=0 in BCAST/SCATTER goes directly to FLUSH with no readies raised.
- In the cycle the last beat is accepted, the state moves to FLUSH and both readies drop in the next cycle. The final beat is never over-consumed.

FLUSH:
- Lasts one cycle; done=1; next state is IDLE.

Pipeline and timing:
- Write outputs are registered: pbuf_wr_* follow the accepting edge by 1 cycle.
- The last write and done are asserted in the same cycle.
- pbuf_wr_en=0 whenever no beat was accepted in the previous cycle.
- Readies are combinational from the FSM state and the partner stream's valid only, never from a stream's own valid.

Reset:
- conf_ready=1 (IDLE), ddr*_ready=0, pbuf_wr_en=0, done=0, pbuf_wr_addr=0, pbuf_wr_data=0.
- rst during RUN aborts the job: no further writes and no done pulse.

Decomposition:
- GLOBAL_PARAM additions: typedef enum logic[1:0] pbuf_mode_e {PB_BCAST, PB_SCATTER, PB_UPDATE, PB_RSVD}, and constant PBUF_GRP = 4.
- Sub-module update_addr_gen: the ch/pix/row counter nest, with step, wrap and last-beat flag. It also produces the address and lane outputs.

Test Plan:
1. BCAST, trans_num=5, mask=0x0000_00F0, ddr2 always valid -> 5 writes at addr 0..4, en=0xF0 each, ddr2 accepts exactly 5 beats, done in the cycle of write 4.
2. SCATTER, GRP=4, trans_num=10, mask=all -> lanes cycle 0,1,2,3; addrs 0,0,0,0,1,1,1,1,2,2; beat 9 asserts only PE p with p%4==1; done after 10 writes.
3. BCAST, trans_num=6, ddr2_valid toggling 1,0,0,1,... -> writes occur only on accepted beats with contiguous addrs 0..5; no duplicated or dropped beats.
4. UPDATE no depool, ch=1, pix=1, row=1 -> 8 accepts; addrs 0,16,0,16,0,16,0,16 (ch in bits 7:4); lane pattern per pix pair 0,0,1,1,2,2,3,3; ddr1 held invalid for 3 cycles stalls both streams.
5. UPDATE depool, ch=0, pix=3, row=1, switch mask 0x1 on ddr2 -> 2 beats; in each write only lane 0 element 0 is nonzero; all masked PEs enabled; done after beat 2.
6. rst asserted mid-BCAST at beat 3 of 8 -> no writes after reset, no done, conf_ready=1 the next cycle; a new conf is then accepted and runs normally.
